regfile_read_port: RTL and testbench

- Read side of the 32 x 32-bit register file.
- Accepts read requests (5-bit address) over a valid/ready handshake and returns the addressed 32-bit value over a valid/ready response channel.
- Consumes the flattened outputs of the 32 storage registers and snoops the write port to bypass same-cycle writes.
- A 2-entry output buffer decouples the consumer; sits between the register storage and the datapath/ALU operand fetch.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_read_port_if.sv | 22 ++
 rtl/regfile_rd_fifo.sv | 60 ++++++
 rtl/regfile_read_port.sv | 71 +++++++
 tb/tb_regfile_read_port.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and buffer entry type for the register file read port
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rd_entry_t;

endpackage

// File: rtl/regfile_read_port_if.sv
// rtl/regfile_read_port_if.sv - request/response handshake bundle of the register file read port
interface regfile_read_port_if;
    import regfile_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr
    );
endinterface

// File: rtl/regfile_rd_fifo.sv
// rtl/regfile_rd_fifo.sv - two-entry synchronous FIFO of read results
module regfile_rd_fifo
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  rd_entry_t push_entry,
    input  logic      pop,
    output rd_entry_t head,
    output logic [1:0] count,
    output logic      full
);

    rd_entry_t [1:0] mem_q, mem_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != 2'd2);
        do_pop   = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == 2'd2);

endmodule

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - register file read port with write bypass and two-entry response buffer
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter bit ZERO_REG0 = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_read_port_if.slave      rd,
    input  logic [NREGS*DATA_W-1:0] regs_flat,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data
);

    rd_entry_t  push_entry;
    rd_entry_t  head;
    rd_entry_t  last_q, last_d;
    logic [1:0] count;
    logic       full;
    logic       push, pop, is_zero_reg;

    // Bypass wins over storage so a read racing a write sees the new value.
    always_comb begin
        is_zero_reg     = ZERO_REG0 && (rd.req_addr == '0);
        push_entry.addr = rd.req_addr;
        if (wr_en && (wr_addr == rd.req_addr) && !is_zero_reg) begin
            push_entry.data = wr_data;
        end else if (is_zero_reg) begin
            push_entry.data = '0;
        end else begin
            push_entry.data = regs_flat[int'(rd.req_addr) * DATA_W +: DATA_W];
        end
    end

    assign rd.req_ready = rst_n && !full;
    assign push         = rd.req_valid && rd.req_ready;
    assign pop          = rd.rsp_valid && rd.rsp_ready;

    regfile_rd_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .full       (full)
    );

    // Remembers the last delivered entry so the outputs hold while empty.
    always_comb begin
        last_d = last_q;
        if (pop) begin
            last_d = head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end

    assign rd.rsp_valid = (count != 2'd0);
    assign rd.rsp_data  = rd.rsp_valid ? head.data : last_q.data;
    assign rd.rsp_addr  = rd.rsp_valid ? head.addr : last_q.addr;

endmodule

// File: tb/tb_regfile_read_port.sv
// tb/tb_regfile_read_port.sv - directed table-driven bench for regfile_read_port
module tb_regfile_read_port;
    import regfile_pkg::*;

    logic clk;
    logic rst_n;
    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    int total;
    int bad;

    regfile_read_port_if bus ();

    regfile_read_port #(.ZERO_REG0(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd        (bus),
        .regs_flat (regs),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] reg_val;
        logic              wen;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{5'd5,  32'h12345678, 1'b0, 5'd0,  32'h0,        32'h12345678};
        vecs[1] = '{5'd9,  32'h00000001, 1'b1, 5'd9,  32'hCAFEF00D, 32'hCAFEF00D};
        vecs[2] = '{5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'hCAFEF00D, 32'h00000000};
        vecs[3] = '{5'd4,  32'h44444444, 1'b1, 5'd3,  32'hBAADBAAD, 32'h44444444};
        vecs[4] = '{5'd31, 32'h1F1F1F1F, 1'b0, 5'd0,  32'h0,        32'h1F1F1F1F};
        vecs[5] = '{5'd0,  32'h77777777, 1'b0, 5'd0,  32'h0,        32'h00000000};

        regs          = '0;
        regs[7]       = 32'hDEADBEEF;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd7;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        #2;
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_rsp_data", bus.rsp_data, 32'd0);
        check("post_rst_rsp_addr", 32'(bus.rsp_addr), 32'd0);
        step();

        for (int v = 0; v < 6; v++) begin
            regs[vecs[v].addr] = vecs[v].reg_val;
            bus.req_valid = 1'b1;
            bus.req_addr  = vecs[v].addr;
            wr_en         = vecs[v].wen;
            wr_addr       = vecs[v].waddr;
            wr_data       = vecs[v].wdata;
            bus.rsp_ready = 1'b1;
            check($sformatf("vec%0d_req_ready", v), 32'(bus.req_ready), 32'd1);
            step();
            bus.req_valid = 1'b0;
            wr_en         = 1'b0;
            check($sformatf("vec%0d_rsp_valid", v), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("vec%0d_rsp_data", v), bus.rsp_data, vecs[v].exp);
            check($sformatf("vec%0d_rsp_addr", v), 32'(bus.rsp_addr), 32'(vecs[v].addr));
            step();
            check($sformatf("vec%0d_drain", v), 32'(bus.rsp_valid), 32'd0);
        end

        // Backpressure: fill both slots, third request must stall.
        regs[1] = 32'h11;
        regs[2] = 32'h22;
        regs[3] = 32'h33;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd1;
        check("bp_ready1", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_addr = 5'd2;
        check("bp_ready2", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_addr = 5'd3;
        check("bp_ready3_full", 32'(bus.req_ready), 32'd0);
        check("bp_head_a", bus.rsp_data, 32'h11);
        step();
        check("bp_still_full", 32'(bus.req_ready), 32'd0);
        check("bp_head_stable", bus.rsp_data, 32'h11);
        check("bp_head_addr", 32'(bus.rsp_addr), 32'd1);
        bus.rsp_ready = 1'b1;
        step();
        check("bp_rsp2", bus.rsp_data, 32'h22);
        check("bp_ready_after_pop", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        check("bp_rsp3", bus.rsp_data, 32'h33);
        check("bp_rsp3_addr", 32'(bus.rsp_addr), 32'd3);
        step();
        check("bp_empty", 32'(bus.rsp_valid), 32'd0);
        check("bp_hold_data", bus.rsp_data, 32'h33);

        // Streaming all addresses with one-cycle latency.
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h01010101;
        regs[0] = 32'hA5A5A5A5;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            if (i < 32) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = 5'(i);
            end else begin
                bus.req_valid = 1'b0;
            end
            if (i > 0) begin
                check($sformatf("stream%0d_valid", i - 1), 32'(bus.rsp_valid), 32'd1);
                check($sformatf("stream%0d_data", i - 1), bus.rsp_data, 32'(i - 1) * 32'h01010101);
                check($sformatf("stream%0d_addr", i - 1), 32'(bus.rsp_addr), 32'(i - 1));
            end
            step();
        end
        check("stream_end_empty", 32'(bus.rsp_valid), 32'd0);

        // Reset between edges with a full buffer.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd10;
        step();
        bus.req_addr = 5'd11;
        step();
        check("mid_full", 32'(bus.req_ready), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_data", bus.rsp_data, 32'd0);
        step();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid_no_stale%0d", i), 32'(bus.rsp_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
